// File: rtl/load_store_unit.sv
// Memory-stage load/store unit: req/ack data-memory port, byte enables, load formatting, stall.
// Define MISALIGN_TRAP_EN to trap misaligned H/W accesses instead of silently aligning them.
module load_store_unit #(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned BE_WIDTH     = 4,
  parameter int unsigned FUNCT3_WIDTH = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    MemReq,
  input  logic                    MemWrite,
  input  logic [FUNCT3_WIDTH-1:0] Funct3,
  input  logic [DATA_WIDTH-1:0]   ALUResult,
  input  logic [DATA_WIDTH-1:0]   WriteData,
  output logic                    Stall,
  output logic [DATA_WIDTH-1:0]   ReadData,
  output logic                    ReadValid,
  output logic                    Misaligned,
  output logic                    DMemReq,
  output logic                    DMemWe,
  output logic [DATA_WIDTH-1:0]   DMemAddr,
  output logic [BE_WIDTH-1:0]     DMemBe,
  output logic [DATA_WIDTH-1:0]   DMemWdata,
  input  logic [DATA_WIDTH-1:0]   DMemRdata,
  input  logic                    DMemAck
);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e                  state_q, state_d;
  logic [FUNCT3_WIDTH-1:0] f3_q;
  logic [1:0]              off_q;
  logic                    req_q, we_q, read_valid_q, misaligned_q;
  logic [DATA_WIDTH-1:0]   addr_q, wdata_q, read_data_q;
  logic [BE_WIDTH-1:0]     be_q;

  logic [BE_WIDTH-1:0]     be_d;
  logic [DATA_WIDTH-1:0]   wdata_d, load_fmt;
  logic [7:0]              ld_byte;
  logic [15:0]             ld_half;
  logic                    trap;

  always_comb begin
    be_d    = 4'b1111;
    wdata_d = WriteData;
    case (Funct3)
      3'b000, 3'b100: begin
        be_d    = 4'b0001 << ALUResult[1:0];
        wdata_d = {4{WriteData[7:0]}};
      end
      3'b001, 3'b101: begin
        be_d    = 4'b0011 << {ALUResult[1], 1'b0};
        wdata_d = {2{WriteData[15:0]}};
      end
      default: ;
    endcase
  end

`ifdef MISALIGN_TRAP_EN
  always_comb begin
    case (Funct3)
      3'b000, 3'b100: trap = 1'b0;
      3'b001, 3'b101: trap = ALUResult[0];
      default:        trap = |ALUResult[1:0];
    endcase
  end
`else
  assign trap = 1'b0;
`endif

  // Lane select uses the latched offset; the raw word is only valid with the ack.
  always_comb begin
    case (off_q)
      2'd0:    ld_byte = DMemRdata[7:0];
      2'd1:    ld_byte = DMemRdata[15:8];
      2'd2:    ld_byte = DMemRdata[23:16];
      default: ld_byte = DMemRdata[31:24];
    endcase
    ld_half = off_q[1] ? DMemRdata[31:16] : DMemRdata[15:0];
    case (f3_q)
      3'b000:  load_fmt = {{24{ld_byte[7]}}, ld_byte};
      3'b100:  load_fmt = {24'b0, ld_byte};
      3'b001:  load_fmt = {{16{ld_half[15]}}, ld_half};
      3'b101:  load_fmt = {16'b0, ld_half};
      default: load_fmt = DMemRdata;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (MemReq) state_d = trap ? StDone : StBusy;
      StBusy:  if (DMemAck) state_d = StDone;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      f3_q         <= '0;
      off_q        <= '0;
      req_q        <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      be_q         <= '0;
      wdata_q      <= '0;
      read_data_q  <= '0;
      read_valid_q <= 1'b0;
      misaligned_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      read_valid_q <= 1'b0;
      misaligned_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (MemReq && trap) begin
            misaligned_q <= 1'b1;
          end else if (MemReq) begin
            f3_q    <= Funct3;
            off_q   <= ALUResult[1:0];
            we_q    <= MemWrite;
            addr_q  <= {ALUResult[DATA_WIDTH-1:2], 2'b00};
            be_q    <= be_d;
            wdata_q <= wdata_d;
            req_q   <= 1'b1;
          end
        end
        StBusy: begin
          if (DMemAck) begin
            req_q <= 1'b0;
            if (!we_q) begin
              read_data_q  <= load_fmt;
              read_valid_q <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign Stall      = ~rst & (((state_q == StIdle) & MemReq) | (state_q == StBusy));
  assign ReadData   = read_data_q;
  assign ReadValid  = read_valid_q;
  assign Misaligned = misaligned_q;
  assign DMemReq    = req_q;
  assign DMemWe     = we_q;
  assign DMemAddr   = addr_q;
  assign DMemBe     = be_q;
  assign DMemWdata  = wdata_q;

endmodule
